ram_master: RTL

Bus initiator for the 32x32 single-port synchronous RAM block. It accepts single or burst read/write requests on a request/busy handshake and drives the RAM's chip-enable, write-enable, address and data lines. It absorbs the RAM's one-cycle registered read latency and returns read words on a valid-qualified stream. It sits between any requesting logic (CPU/bus fabric, DMA, test sequencer) and one RAM instance.

---
 rtl/ram_master.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ram_master.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ram_master: burst read/write initiator for a 32x32 single-port RAM    |
// | Optional: RAM_MASTER_STATS_EN adds wr_count / rd_count statistics.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module ram_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_wr,
  input  logic [4:0]  req_addr,
  input  logic [2:0]  req_len,
  output logic        busy,
  output logic        done,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        ram_cen,
  output logic        ram_wen,
  output logic [4:0]  ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
`ifdef RAM_MASTER_STATS_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cur_addr;
  logic [2:0]  r_beats_left;
  logic        r_rd_pend;
  logic        r_busy;
  logic        r_done;
  logic        r_cen;
  logic        r_wen;

  logic        w_last_beat;

  assign w_last_beat = (r_beats_left == 3'd0);

  // Control flags are updated alongside the state so every strobe is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= 5'd0;
      r_beats_left <= 3'd0;
      r_rd_pend    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cen        <= 1'b0;
      r_wen        <= 1'b0;
    end else begin
      r_rd_pend <= (r_state == S_READ);
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_cur_addr   <= req_addr;
            r_beats_left <= req_len;
            r_busy       <= 1'b1;
            r_cen        <= 1'b1;
            r_wen        <= req_wr;
            r_state      <= req_wr ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          r_cur_addr   <= r_cur_addr + 5'd1;
          r_beats_left <= r_beats_left - 3'd1;
          if (w_last_beat) begin
            r_cen   <= 1'b0;
            r_wen   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_READ: begin
          r_cur_addr   <= r_cur_addr + 5'd1;
          r_beats_left <= r_beats_left - 3'd1;
          if (w_last_beat) begin
            r_cen   <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Final read word is on ram_dout this cycle; rd_pend covers it.
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cen   <= 1'b0;
          r_wen   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign wr_ready = r_wen;
  assign ram_cen  = r_cen;
  assign ram_wen  = r_wen;
  assign ram_addr = r_cen ? r_cur_addr : 5'd0;
  assign ram_din  = r_wen ? wr_data : 32'd0;
  assign rd_valid = r_rd_pend;
  assign rd_data  = ram_dout;

`ifdef RAM_MASTER_STATS_EN
  logic [15:0] r_wr_count;
  logic [15:0] r_rd_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_count <= 16'd0;
      r_rd_count <= 16'd0;
    end else begin
      if (r_state == S_WRITE) r_wr_count <= r_wr_count + 16'd1;
      if (r_rd_pend)          r_rd_count <= r_rd_count + 16'd1;
    end
  end

  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;
`endif

endmodule
`default_nettype wire
